// File: rtl/button_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_queue
//  Description : Turns debounced button levels into a show-ahead FIFO of
//                press/release events, lowest button index first.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event_queue #(
    parameter int NUM_BUTTONS = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_BUTTONS-1:0]          buttons_in,
    input  logic                            rd_en,
    input  logic                            clear_overflow,
    output logic [15:0]                     rd_data,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overflow
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(FIFO_DEPTH);

    logic [NUM_BUTTONS-1:0] r_prev;
    logic [NUM_BUTTONS-1:0] r_pending;
    logic [NUM_BUTTONS-1:0] r_pend_type;
    logic [15:0]            r_mem [FIFO_DEPTH];
    logic [c_PW-1:0]        r_wr_ptr;
    logic [c_PW-1:0]        r_rd_ptr;
    logic [c_CW-1:0]        r_count;
    logic                   r_overflow;

    logic [NUM_BUTTONS-1:0] w_edge;
    logic [NUM_BUTTONS-1:0] w_pending_nxt;
    logic [NUM_BUTTONS-1:0] w_type_nxt;
    logic                   w_coalesce;
    logic                   w_cand_valid;
    logic [7:0]             w_cand_idx;
    logic                   w_cand_type;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push;
    logic [15:0]            w_entry;

    assign w_edge  = buttons_in ^ r_prev;
    assign w_empty = (r_count == '0);
    assign w_pop   = rd_en && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = w_cand_valid && ((r_count < c_FULL_COUNT) || w_pop);
    assign w_entry = {1'b1, w_cand_type, 6'b0, w_cand_idx};

    // Lowest pending index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_idx   = 8'd0;
        w_cand_type  = 1'b0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_cand_valid = 1'b1;
                w_cand_idx   = 8'(i);
                w_cand_type  = r_pend_type[i];
            end
        end
    end

    always_comb begin
        w_pending_nxt = r_pending;
        w_type_nxt    = r_pend_type;
        w_coalesce    = 1'b0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (w_edge[i]) begin
                w_pending_nxt[i] = 1'b1;
                w_type_nxt[i]    = buttons_in[i];
                // An edge landing on the cycle its old event leaves is a fresh event.
                if (r_pending[i] && !(w_push && (w_cand_idx == 8'(i)))) begin
                    w_coalesce = 1'b1;
                end
            end else if (w_push && (w_cand_idx == 8'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev      <= '0;
            r_pending   <= '0;
            r_pend_type <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_prev      <= buttons_in;
            r_pending   <= w_pending_nxt;
            r_pend_type <= w_type_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_coalesce) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage needs no reset: rd_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    assign rd_data  = w_empty ? 16'h0000 : r_mem[r_rd_ptr];
    assign empty    = w_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_button_event_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event_queue
//  Description : Directed scoreboard bench for button_event_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_queue;

    localparam int NB = 16;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic [NB-1:0] buttons_in;
    logic          rd_en;
    logic          clear_overflow;
    logic [15:0]   rd_data;
    logic          empty;
    logic [3:0]    count;
    logic          overflow;

    int n_vec;
    int n_err;
    logic [15:0] exp_q [$];

    button_event_queue #(.NUM_BUTTONS(NB), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .buttons_in     (buttons_in),
        .rd_en          (rd_en),
        .clear_overflow (clear_overflow),
        .rd_data        (rd_data),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted read is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 32'(rd_data), 32'hFFFF_FFFF);
            end else begin
                check("read_entry", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        buttons_in = '0;
        rd_en = 1'b0;
        clear_overflow = 1'b0;
        step(2);
        reset = 1'b0;

        // Idle after reset
        step(5);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_count", 32'(count), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_overflow", 32'(overflow), 32'd0);

        // Single press, two-edge latency
        buttons_in[3] = 1'b1;
        exp_q.push_back(16'hC003);
        step(1);
        check("lat_still_empty", 32'(empty), 32'd1);
        step(1);
        check("single_empty", 32'(empty), 32'd0);
        check("single_count", 32'(count), 32'd1);
        check("single_rd_data", 32'(rd_data), 32'hC003);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("single_drained", 32'(empty), 32'd1);

        // Simultaneous presses serialise lowest index first
        buttons_in[5] = 1'b1;
        buttons_in[2] = 1'b1;
        exp_q.push_back(16'hC002);
        exp_q.push_back(16'hC005);
        step(3);
        check("dual_count", 32'(count), 32'd2);
        rd_en = 1'b1;
        step(2);
        rd_en = 1'b0;
        check("dual_drained", 32'(empty), 32'd1);

        // Fill to capacity, ninth event waits then enters on a pop
        buttons_in[15:8] = 8'hFF;
        for (int i = 8; i < 16; i++) exp_q.push_back(16'hC000 | 16'(i));
        step(9);
        check("full_count", 32'(count), 32'd8);
        buttons_in[0] = 1'b1;
        exp_q.push_back(16'hC000);
        step(2);
        check("full_waits", 32'(count), 32'd8);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("pop_push_count", 32'(count), 32'd8);
        check("pop_push_ovf", 32'(overflow), 32'd0);

        // Coalesce press+release while full
        buttons_in[1] = 1'b1;
        step(1);
        check("press_pending_ovf", 32'(overflow), 32'd0);
        buttons_in[1] = 1'b0;
        exp_q.push_back(16'h8001);
        step(1);
        check("coalesce_ovf", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        check("clear_ovf", 32'(overflow), 32'd0);
        rd_en = 1'b1;
        step(9);
        rd_en = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_count", 32'(count), 32'd0);

        // Asynchronous reset with four releases queued (these are discarded)
        buttons_in[11:8] = 4'h0;
        step(5);
        check("pre_reset_count", 32'(count), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_empty", 32'(empty), 32'd1);
        check("async_rd_data", 32'(rd_data), 32'h0);
        step(2);
        reset = 1'b0;

        // Buttons held through reset come back as press events
        exp_q.push_back(16'hC000);
        exp_q.push_back(16'hC002);
        exp_q.push_back(16'hC003);
        exp_q.push_back(16'hC005);
        for (int i = 12; i < 16; i++) exp_q.push_back(16'hC000 | 16'(i));
        step(10);
        check("held_count", 32'(count), 32'd8);
        check("held_ovf", 32'(overflow), 32'd0);
        check("held_head", 32'(rd_data), 32'hC000);
        rd_en = 1'b1;
        step(8);
        rd_en = 1'b0;
        check("final_empty", 32'(empty), 32'd1);
        check("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
